// File: rtl/uart_rx_baud_if.sv
// rtl/uart_rx_baud_if.sv - serial line and received-byte signals of uart_rx_baud
//
// Signals:
//   rxd       serial line toward the receiver, idle high
//   baud_sel  rate code (0=9600 .. 4=115200, 5..7 fall back to BAUD_MIN)
//   rx_data   last correctly framed byte
//   rx_done   one-cycle strobe when rx_data updates
//   frame_err one-cycle strobe when a stop bit samples low
//   rx_busy   receiver is inside a frame
// master drives the line (board/bench side), slave is the receiver.
interface uart_rx_baud_if;
    logic       rxd;
    logic [2:0] baud_sel;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       frame_err;
    logic       rx_busy;

    modport master (
        output rxd,
        output baud_sel,
        input  rx_data,
        input  rx_done,
        input  frame_err,
        input  rx_busy
    );

    modport slave (
        input  rxd,
        input  baud_sel,
        output rx_data,
        output rx_done,
        output frame_err,
        output rx_busy
    );
endinterface

// File: rtl/uart_rx_baud.sv
// rtl/uart_rx_baud.sv - 8N1 UART receiver with run-time selectable baud rate
//
// Ports:
//   sys_clk    system clock, rising edge
//   sys_rst_n  asynchronous active-low reset
//   rx_if      uart_rx_baud_if.slave: rxd/baud_sel in, rx_data/rx_done/frame_err/rx_busy out
// Frames start on a falling edge of the synchronized line, the start bit is
// re-checked at its middle, data and stop bits are sampled one bit period
// later each. The receiver returns to idle at mid-stop-bit so that
// back-to-back frames with a single stop bit are accepted.
module uart_rx_baud #(
    parameter int SYS_CLK_FREQ = 50_000_000,
    parameter int BAUD_MIN     = 9600
) (
    input  logic           sys_clk,
    input  logic           sys_rst_n,
    uart_rx_baud_if.slave  rx_if
);

    // Counter wide enough for the slowest rate that can be selected.
    localparam int BAUD_SLOW = (BAUD_MIN < 9600) ? BAUD_MIN : 9600;
    localparam int CW        = $clog2(SYS_CLK_FREQ / BAUD_SLOW + 1);

    localparam logic [CW-1:0] DIV_9600   = CW'(SYS_CLK_FREQ / 9600);
    localparam logic [CW-1:0] DIV_19200  = CW'(SYS_CLK_FREQ / 19200);
    localparam logic [CW-1:0] DIV_38400  = CW'(SYS_CLK_FREQ / 38400);
    localparam logic [CW-1:0] DIV_57600  = CW'(SYS_CLK_FREQ / 57600);
    localparam logic [CW-1:0] DIV_115200 = CW'(SYS_CLK_FREQ / 115200);
    localparam logic [CW-1:0] DIV_MIN    = CW'(SYS_CLK_FREQ / BAUD_MIN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t        r_state;
    logic          r_rxd_meta;
    logic          r_rxd_sync;
    logic          r_rxd_prev;
    logic [CW-1:0] r_div;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic [7:0]    r_rx_data;
    logic          r_rx_done;
    logic          r_frame_err;
    logic          r_rx_busy;

    logic [CW-1:0] w_div_sel;
    logic          w_fall;
    logic          w_half_hit;
    logic          w_full_hit;

    always_comb begin
        w_div_sel = DIV_MIN;
        case (rx_if.baud_sel)
            3'd0:    w_div_sel = DIV_9600;
            3'd1:    w_div_sel = DIV_19200;
            3'd2:    w_div_sel = DIV_38400;
            3'd3:    w_div_sel = DIV_57600;
            3'd4:    w_div_sel = DIV_115200;
            default: w_div_sel = DIV_MIN;
        endcase
    end

    // Synchronizer registers reset low: a line held low through reset
    // release must not look like a start edge.
    assign w_fall     = r_rxd_prev & ~r_rxd_sync;
    assign w_half_hit = (r_cnt == ((r_div >> 1) - CW'(1)));
    assign w_full_hit = (r_cnt == (r_div - CW'(1)));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_rxd_meta  <= 1'b0;
            r_rxd_sync  <= 1'b0;
            r_rxd_prev  <= 1'b0;
            r_state     <= S_IDLE;
            r_div       <= '0;
            r_cnt       <= '0;
            r_bit_idx   <= 3'd0;
            r_shift     <= 8'h00;
            r_rx_data   <= 8'h00;
            r_rx_done   <= 1'b0;
            r_frame_err <= 1'b0;
            r_rx_busy   <= 1'b0;
        end else begin
            r_rxd_meta  <= rx_if.rxd;
            r_rxd_sync  <= r_rxd_meta;
            r_rxd_prev  <= r_rxd_sync;
            r_rx_done   <= 1'b0;
            r_frame_err <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (w_fall) begin
                        // Rate is frozen for the whole frame.
                        r_div     <= w_div_sel;
                        r_state   <= S_START;
                        r_rx_busy <= 1'b1;
                    end
                end

                S_START: begin
                    if (w_half_hit) begin
                        r_cnt <= '0;
                        if (!r_rxd_sync) begin
                            r_state   <= S_DATA;
                            r_bit_idx <= 3'd0;
                        end else begin
                            // Line went back high before mid-start: glitch.
                            r_state   <= S_IDLE;
                            r_rx_busy <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end

                S_DATA: begin
                    if (w_full_hit) begin
                        r_cnt              <= '0;
                        r_shift[r_bit_idx] <= r_rxd_sync;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end

                S_STOP: begin
                    if (w_full_hit) begin
                        r_cnt     <= '0;
                        r_state   <= S_IDLE;
                        r_rx_busy <= 1'b0;
                        if (r_rxd_sync) begin
                            r_rx_data <= r_shift;
                            r_rx_done <= 1'b1;
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end

                default: begin
                    r_state   <= S_IDLE;
                    r_cnt     <= '0;
                    r_rx_busy <= 1'b0;
                end
            endcase
        end
    end

    assign rx_if.rx_data   = r_rx_data;
    assign rx_if.rx_done   = r_rx_done;
    assign rx_if.frame_err = r_frame_err;
    assign rx_if.rx_busy   = r_rx_busy;

endmodule

// File: tb/tb_uart_rx_baud.sv
// tb/tb_uart_rx_baud.sv - self-checking bench for uart_rx_baud
module tb_uart_rx_baud;

    // Slow system clock keeps 9600-baud frames short in cycles.
    localparam int SYS_CLK_FREQ = 2_000_000;
    localparam int BAUD_MIN     = 9600;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;

    uart_rx_baud_if rx_if();

    uart_rx_baud #(
        .SYS_CLK_FREQ (SYS_CLK_FREQ),
        .BAUD_MIN     (BAUD_MIN)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .rx_if     (rx_if)
    );

    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_fail   = 0;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int          done_cnt = 0;
    int          ferr_cnt = 0;
    int          both_cnt = 0;
    int          last_done_cyc = 0;
    int          last_ferr_cyc = 0;
    logic [7:0]  last_done_data = 8'h00;

    always @(negedge sys_clk) begin
        if (rx_if.rx_done === 1'b1) begin
            done_cnt++;
            last_done_cyc  = cyc;
            last_done_data = rx_if.rx_data;
        end
        if (rx_if.frame_err === 1'b1) begin
            ferr_cnt++;
            last_ferr_cyc = cyc;
        end
        if (rx_if.rx_done === 1'b1 && rx_if.frame_err === 1'b1) both_cnt++;
    end

    // Reference: last good byte the line carried (0 after reset).
    logic [7:0] exp_data = 8'h00;
    int         start_cyc = 0;

    function automatic int div_for(input int sel);
        int baud;
        case (sel)
            0:       baud = 9600;
            1:       baud = 19200;
            2:       baud = 38400;
            3:       baud = 57600;
            4:       baud = 115200;
            default: baud = BAUD_MIN;
        endcase
        return SYS_CLK_FREQ / baud;
    endfunction

    task automatic send_bit(input logic v, input int div);
        rx_if.rxd = v;
        repeat (div) @(negedge sys_clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input int div, input logic stop_v,
                              input int nstop, input int sw_bit, input logic [2:0] sw_sel);
        start_cyc = cyc;
        send_bit(1'b0, div);
        for (int i = 0; i < 8; i++) begin
            if (i == sw_bit) rx_if.baud_sel = sw_sel;
            send_bit(b[i], div);
        end
        for (int s = 0; s < nstop; s++) send_bit(stop_v, div);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge sys_clk);
        n_checks++;
        if ({rx_if.rx_data, rx_if.rx_done, rx_if.frame_err, rx_if.rx_busy} !== 11'h000) begin
            n_fail++;
            $display("FAIL reset_outputs: got data=%h done=%b ferr=%b busy=%b expected 00/0/0/0",
                     rx_if.rx_data, rx_if.rx_done, rx_if.frame_err, rx_if.rx_busy);
        end
        sys_rst_n = 1'b1;
        repeat (10) @(negedge sys_clk);
        n_checks++;
        if (rx_if.rx_busy !== 1'b0 || done_cnt != 0 || ferr_cnt != 0) begin
            n_fail++;
            $display("FAIL reset_idle: got busy=%b done=%0d ferr=%0d expected 0/0/0",
                     rx_if.rx_busy, done_cnt, ferr_cnt);
        end
    endtask

    task automatic test_basic_9600();
        int d0, f0, div, lo, n;
        div = div_for(0);
        rx_if.baud_sel = 3'd0;
        d0 = done_cnt;
        f0 = ferr_cnt;
        send_frame(8'h55, div, 1'b1, 2, -1, 3'd0);
        exp_data = 8'h55;
        n_checks++;
        if (done_cnt != d0 + 1) begin
            n_fail++;
            $display("FAIL basic_done_count: got %0d expected %0d", done_cnt - d0, 1);
        end
        n_checks++;
        if (rx_if.rx_data !== exp_data || last_done_data !== exp_data) begin
            n_fail++;
            $display("FAIL basic_data: got %h expected %h", rx_if.rx_data, exp_data);
        end
        n_checks++;
        if (ferr_cnt != f0) begin
            n_fail++;
            $display("FAIL basic_no_ferr: got %0d expected 0", ferr_cnt - f0);
        end
        lo = 9 * div + div / 2;
        n  = last_done_cyc - start_cyc;
        n_checks++;
        if (n < lo || n > lo + 4) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d expected %0d..%0d", n, lo, lo + 4);
        end
    endtask

    task automatic test_rates();
        logic [7:0] pat [4];
        int d0, div;
        pat = '{8'hA3, 8'hB7, 8'h89, 8'h89};
        for (int k = 0; k < 4; k++) begin
            rx_if.baud_sel = 3'(k + 1);
            div = div_for(k + 1);
            d0  = done_cnt;
            send_frame(pat[k], div, 1'b1, 1, -1, 3'd0);
            exp_data = pat[k];
            n_checks++;
            if (done_cnt != d0 + 1) begin
                n_fail++;
                $display("FAIL rate%0d_done_count: got %0d expected 1", k + 1, done_cnt - d0);
            end
            n_checks++;
            if (rx_if.rx_data !== exp_data) begin
                n_fail++;
                $display("FAIL rate%0d_data: got %h expected %h", k + 1, rx_if.rx_data, exp_data);
            end
            n_checks++;
            if (rx_if.rx_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL rate%0d_busy_between: got %b expected 0", k + 1, rx_if.rx_busy);
            end
            repeat (5) @(negedge sys_clk);
        end
    endtask

    task automatic test_framing();
        int d0, f0, div, lo, n;
        rx_if.baud_sel = 3'd4;
        div = div_for(4);
        d0 = done_cnt;
        f0 = ferr_cnt;
        send_frame(8'h00, div, 1'b0, 1, -1, 3'd0);
        repeat (3 * div) @(negedge sys_clk);
        n_checks++;
        if (ferr_cnt != f0 + 1 || done_cnt != d0) begin
            n_fail++;
            $display("FAIL framing_strobes: got ferr=%0d done=%0d expected 1/0",
                     ferr_cnt - f0, done_cnt - d0);
        end
        n_checks++;
        if (rx_if.rx_data !== exp_data) begin
            n_fail++;
            $display("FAIL framing_data_kept: got %h expected %h", rx_if.rx_data, exp_data);
        end
        lo = 9 * div + div / 2;
        n  = last_ferr_cyc - start_cyc;
        n_checks++;
        if (n < lo || n > lo + 4) begin
            n_fail++;
            $display("FAIL framing_latency: got %0d expected %0d..%0d", n, lo, lo + 4);
        end
        n_checks++;
        if (rx_if.rx_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL framing_stuck_low_busy: got %b expected 0", rx_if.rx_busy);
        end
        rx_if.rxd = 1'b1;
        repeat (2 * div) @(negedge sys_clk);
        d0 = done_cnt;
        send_frame(8'h3C, div, 1'b1, 1, -1, 3'd0);
        exp_data = 8'h3C;
        n_checks++;
        if (done_cnt != d0 + 1 || rx_if.rx_data !== exp_data || ferr_cnt != f0 + 1) begin
            n_fail++;
            $display("FAIL framing_recovery: got done=%0d data=%h ferr=%0d expected 1/%h/1",
                     done_cnt - d0, rx_if.rx_data, exp_data, ferr_cnt - f0);
        end
    endtask

    task automatic test_glitch();
        int d0, f0, div, waited;
        rx_if.baud_sel = 3'd2;
        div = div_for(2);
        d0 = done_cnt;
        f0 = ferr_cnt;
        rx_if.rxd = 1'b0;
        repeat (div / 4) @(negedge sys_clk);
        rx_if.rxd = 1'b1;
        n_checks++;
        if (rx_if.rx_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL glitch_busy_high: got %b expected 1", rx_if.rx_busy);
        end
        waited = 0;
        while (rx_if.rx_busy === 1'b1 && waited < div) begin
            @(negedge sys_clk);
            waited++;
        end
        n_checks++;
        if (rx_if.rx_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_busy_drop: got %b expected 0 within %0d cycles", rx_if.rx_busy, div);
        end
        repeat (2 * div) @(negedge sys_clk);
        n_checks++;
        if (done_cnt != d0 || ferr_cnt != f0) begin
            n_fail++;
            $display("FAIL glitch_no_strobe: got done=%0d ferr=%0d expected 0/0",
                     done_cnt - d0, ferr_cnt - f0);
        end
        send_frame(8'hF0, div, 1'b1, 1, -1, 3'd0);
        exp_data = 8'hF0;
        n_checks++;
        if (done_cnt != d0 + 1 || rx_if.rx_data !== exp_data) begin
            n_fail++;
            $display("FAIL glitch_next_frame: got done=%0d data=%h expected 1/%h",
                     done_cnt - d0, rx_if.rx_data, exp_data);
        end
    endtask

    task automatic test_baud_switch();
        int d0, lo, n, div;
        logic [7:0] b;
        rx_if.baud_sel = 3'd0;
        d0 = done_cnt;
        send_frame(8'h5A, div_for(0), 1'b1, 1, 4, 3'd4);
        exp_data = 8'h5A;
        n_checks++;
        if (done_cnt != d0 + 1 || rx_if.rx_data !== exp_data) begin
            n_fail++;
            $display("FAIL switch_old_rate: got done=%0d data=%h expected 1/%h",
                     done_cnt - d0, rx_if.rx_data, exp_data);
        end
        repeat (10) @(negedge sys_clk);
        b   = 8'($urandom_range(0, 255));
        div = div_for(4);
        d0  = done_cnt;
        send_frame(b, div, 1'b1, 1, -1, 3'd0);
        exp_data = b;
        lo = 9 * div + div / 2;
        n  = last_done_cyc - start_cyc;
        n_checks++;
        if (done_cnt != d0 + 1 || rx_if.rx_data !== exp_data || n < lo || n > lo + 4) begin
            n_fail++;
            $display("FAIL switch_new_rate: got done=%0d data=%h lat=%0d expected 1/%h/%0d..%0d",
                     done_cnt - d0, rx_if.rx_data, n, exp_data, lo, lo + 4);
        end
    endtask

    task automatic test_reset_midframe();
        int d0, f0, div;
        logic [7:0] ab;
        ab = 8'hE7;
        rx_if.baud_sel = 3'd0;
        div = div_for(0);
        d0 = done_cnt;
        f0 = ferr_cnt;
        send_bit(1'b0, div);
        for (int i = 0; i < 4; i++) send_bit(ab[i], div);
        rx_if.rxd = ab[4];
        repeat (div / 2) @(negedge sys_clk);
        sys_rst_n = 1'b0;
        #1;
        exp_data = 8'h00;
        n_checks++;
        if ({rx_if.rx_data, rx_if.rx_done, rx_if.frame_err, rx_if.rx_busy} !== 11'h000) begin
            n_fail++;
            $display("FAIL midreset_outputs: got data=%h done=%b ferr=%b busy=%b expected 00/0/0/0",
                     rx_if.rx_data, rx_if.rx_done, rx_if.frame_err, rx_if.rx_busy);
        end
        repeat (4) @(negedge sys_clk);
        rx_if.rxd = 1'b1;
        sys_rst_n = 1'b1;
        repeat (6 * div) @(negedge sys_clk);
        n_checks++;
        if (done_cnt != d0 || ferr_cnt != f0 || rx_if.rx_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_aborted: got done=%0d ferr=%0d busy=%b expected 0/0/0",
                     done_cnt - d0, ferr_cnt - f0, rx_if.rx_busy);
        end
        send_frame(8'h81, div, 1'b1, 1, -1, 3'd0);
        exp_data = 8'h81;
        n_checks++;
        if (done_cnt != d0 + 1 || rx_if.rx_data !== exp_data) begin
            n_fail++;
            $display("FAIL midreset_next_frame: got done=%0d data=%h expected 1/%h",
                     done_cnt - d0, rx_if.rx_data, exp_data);
        end
    endtask

    task automatic test_random();
        int sel, div, nstop, gap, d0, lo, n;
        logic [7:0] b;
        for (int k = 0; k < 6; k++) begin
            sel   = $urandom_range(0, 7);
            div   = div_for(sel);
            b     = 8'($urandom_range(0, 255));
            nstop = $urandom_range(1, 2);
            gap   = $urandom_range(0, 20);
            rx_if.baud_sel = 3'(sel);
            d0 = done_cnt;
            send_frame(b, div, 1'b1, nstop, -1, 3'd0);
            exp_data = b;
            lo = 9 * div + div / 2;
            n  = last_done_cyc - start_cyc;
            n_checks++;
            if (done_cnt != d0 + 1 || rx_if.rx_data !== exp_data) begin
                n_fail++;
                $display("FAIL random%0d_frame sel=%0d: got done=%0d data=%h expected 1/%h",
                         k, sel, done_cnt - d0, rx_if.rx_data, exp_data);
            end
            n_checks++;
            if (n < lo || n > lo + 4) begin
                n_fail++;
                $display("FAIL random%0d_latency sel=%0d: got %0d expected %0d..%0d",
                         k, sel, n, lo, lo + 4);
            end
            repeat (gap) @(negedge sys_clk);
        end
    endtask

    task automatic test_exclusive();
        n_checks++;
        if (both_cnt != 0) begin
            n_fail++;
            $display("FAIL done_ferr_exclusive: got %0d overlaps expected 0", both_cnt);
        end
    endtask

    initial begin
        rx_if.rxd      = 1'b1;
        rx_if.baud_sel = 3'd0;
        @(negedge sys_clk);
        test_reset();
        test_basic_9600();
        test_rates();
        test_framing();
        test_glitch();
        test_baud_switch();
        test_reset_midframe();
        test_random();
        test_exclusive();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_baud.md
Name: uart_rx_baud

Overview:
UART receiver front-end of the uart_vga datapath. It sits between the board rxd pin and the display/VGA consumers. It recovers 8N1 bytes (extra stop bits tolerated) at one of five run-time-selectable baud rates. Each received byte is presented with a one-cycle strobe, plus a framing-error flag and a busy indication.

Parameters:
SYS_CLK_FREQ, 50_000_000, system clock frequency in Hz; all bit-period divisors derive from it.
BAUD_MIN, 9600, fallback rate used for unlisted baud_sel codes.

Ports:
sys_clk  input  1  system clock; all logic on its rising edge.
sys_rst_n  input  1  asynchronous, active-low reset.
rxd  input  1  serial line, idle high, asynchronous to sys_clk.
baud_sel  input  3  rate code: 0=9600, 1=19200, 2=38400, 3=57600, 4=115200; 5..7 = BAUD_MIN.
rx_data  output  8  last correctly framed byte, LSB received first.
rx_done  output  1  one-cycle pulse when rx_data is updated.
frame_err  output  1  one-cycle pulse when the stop bit samples low.
rx_busy  output  1  high from start-bit acceptance until return to IDLE.

Behaviour:
- Clock and reset: one clock (sys_clk). Reset is asynchronous, active-low (sys_rst_n).
- Reset values: rx_data=8'h00, rx_done=0, frame_err=0, rx_busy=0, FSM=IDLE, all counters 0.
- Reset mid-frame aborts immediately. The partial byte is discarded and no strobe is issued.
- Input path:
  - rxd passes through a 2-FF synchronizer, then a third register for edge detection.
  - A falling edge = previous synced 1, current synced 0.
- Divisor DIV = SYS_CLK_FREQ/baud, integer-truncated: 5208, 2604, 1302, 868, 434 at 50 MHz.
- DIV is latched from baud_sel only in IDLE when the falling edge is accepted. baud_sel changes mid-frame have no effect until the next frame.
- Bit counter: cnt counts 0..DIV-1 and wraps. bit_idx is 0..7.
- FSM states:
  - IDLE: rx_busy=0. On falling edge → START, cnt=0, latch DIV, rx_busy=1.
  - START: at cnt=DIV/2-1, sample synced rxd.
    - 0 → DATA, cnt=0, bit_idx=0.
    - 1 → IDLE (glitch rejected, no strobe).
  - DATA: at cnt=DIV-1 (mid-bit), shift the sample into shift[bit_idx] (LSB first).
    - bit_idx=7 → STOP, cnt=0.
    - otherwise bit_idx+1.
  - STOP: at cnt=DIV-1, sample the stop bit.
    - 1 → rx_data<=shift, rx_done=1 for exactly one cycle.
    - 0 → frame_err=1 for one cycle; rx_data unchanged.
    - Either way → IDLE next cycle; rx_busy drops in the same cycle as the strobe.
- Return to IDLE happens at mid-stop-bit, so back-to-back frames with a single stop bit are received.
- Additional stop bits and idle time are ignored.
- Framing-error recovery: while rxd is stuck low after a framing error, no new frame starts until the synced line goes high and then falls again.
- rx_done and frame_err are never high together.
- Latency: rx_done/frame_err rises N cycles after the rxd pin falling edge, with 9*DIV+DIV/2 ≤ N ≤ 9*DIV+DIV/2+4.
- The divider is exact only to integer truncation; baud error ≤0.03% at 115200 with 50 MHz.

Test Plan:
1. baud_sel=0; send 0x55 at 5208 clk/bit with 2 stop bits → single rx_done pulse, rx_data=8'h55, frame_err=0; rx_done within the latency window (≈49476 cycles after the start edge).
2. Run baud_sel 1/2/3/4 sequentially, sending 0xA3, 0xB7, 0x89, 0x89 at 2604/1302/868/434 clk/bit → one rx_done per frame with matching rx_data; rx_busy low between frames.
3. baud_sel=4; send 0x00 with the stop bit held low, then release rxd high → frame_err pulse, no rx_done, rx_data keeps its prior value; the next valid frame 0x3C is received correctly.
4. baud_sel=2; 200-cycle low glitch on rxd → no rx_done/frame_err, rx_busy high <700 cycles then low; a following 0xF0 frame is received.
5. baud_sel=0 at start, switched to 4 at mid-frame of 0x5A → byte received correctly at 9600 (rx_data=8'h5A); the next frame uses 115200.
6. Assert sys_rst_n low during bit 4 of a 9600 frame, deassert, then send 0x81 → outputs at reset values immediately; no strobe for the aborted frame; 0x81 received.
